// File: rtl/hazard_ctrl.sv
// Front-end sequencing for the five-stage core: load-use, mult/div and redirect control.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MemRead_ex,
    input  logic [4:0] Rt_ex,
    input  logic [4:0] Rs_id,
    input  logic [4:0] Rt_id,
    input  logic       UsesRt_id,
    input  logic       Branch,
    input  logic       Jump,
    input  logic       MulDiv_id,
    input  logic       HiLo_id,
    output logic       IFWrite,
    output logic       IF_flush,
    output logic       IFIDWrite,
    output logic       Bubble_ex,
    output logic       MdStart,
`ifdef HAZARD_PERF_EN
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt,
`endif
    output logic       MdBusy
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lu, md, stall;

    assign lu    = MemRead_ex && (Rt_ex != 5'd0) &&
                   ((Rt_ex == Rs_id) || (UsesRt_id && (Rt_ex == Rt_id)));
    assign md    = (state == BUSY) && (HiLo_id || MulDiv_id);
    assign stall = lu || md;

    // Reset looks like a stall to the front end so nothing advances.
    always_comb begin
        IFWrite   = 1'b0;
        IFIDWrite = 1'b0;
        Bubble_ex = 1'b1;
        IF_flush  = 1'b0;
        MdStart   = 1'b0;
        if (!reset && !stall) begin
            IFWrite   = 1'b1;
            IFIDWrite = 1'b1;
            Bubble_ex = 1'b0;
            IF_flush  = Branch || Jump;
            MdStart   = MulDiv_id && (state == RUN);
        end
    end

    assign MdBusy = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (MdStart) begin
            state <= BUSY;
            cnt   <= CNT_W'(MULDIV_CYCLES);
        end else if (state == BUSY) begin
            if (cnt == CNT_W'(1)) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stall && (StallCnt != 32'hFFFF_FFFF)) StallCnt <= StallCnt + 32'd1;
            if (IF_flush && (FlushCnt != 32'hFFFF_FFFF)) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MULDIV_CYCLES = 4); expected output vectors go through a scoreboard queue.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       MemRead_ex;
    logic [4:0] Rt_ex, Rs_id, Rt_id;
    logic       UsesRt_id, Branch, Jump, MulDiv_id, HiLo_id;
    logic       IFWrite, IF_flush, IFIDWrite, Bubble_ex, MdStart, MdBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .MemRead_ex(MemRead_ex), .Rt_ex(Rt_ex),
        .Rs_id(Rs_id), .Rt_id(Rt_id), .UsesRt_id(UsesRt_id), .Branch(Branch),
        .Jump(Jump), .MulDiv_id(MulDiv_id), .HiLo_id(HiLo_id),
        .IFWrite(IFWrite), .IF_flush(IF_flush), .IFIDWrite(IFIDWrite),
        .Bubble_ex(Bubble_ex), .MdStart(MdStart),
`ifdef HAZARD_PERF_EN
        .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
        .MdBusy(MdBusy));

    always #5 clk = ~clk;

    // {IFWrite, IF_flush, IFIDWrite, Bubble_ex, MdStart}
    localparam logic [4:0] STL = 5'b00010;
    localparam logic [4:0] NRM = 5'b10100;
    localparam logic [4:0] FLS = 5'b11100;
    localparam logic [4:0] STA = 5'b10101;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } sb_t;
    sb_t sb[$];

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // One cycle: drive inputs, push expectation, sample at the falling edge, advance.
    task automatic step(input string tag, input logic rst, input logic mr, input logic [4:0] rtex,
                        input logic [4:0] rsid, input logic [4:0] rtid, input logic urt,
                        input logic br, input logic jp, input logic mdv, input logic hl,
                        input logic [4:0] o, input logic busy);
        sb_t e, a;
        logic [5:0] obs;
        reset = rst; MemRead_ex = mr; Rt_ex = rtex; Rs_id = rsid; Rt_id = rtid;
        UsesRt_id = urt; Branch = br; Jump = jp; MulDiv_id = mdv; HiLo_id = hl;
        e.tag = tag; e.exp = {o, busy};
        sb.push_back(e);
        if (rst) begin
            exp_stall = 0; exp_flush = 0;
        end else begin
            if (o == STL) exp_stall++;
            if (o == FLS) exp_flush++;
        end
        @(negedge clk);
        a = sb.pop_front();
        obs = {IFWrite, IF_flush, IFIDWrite, Bubble_ex, MdStart, MdBusy};
        checks++;
        assert (obs === a.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", a.tag, obs, a.exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; MemRead_ex = 1'b0; Rt_ex = '0; Rs_id = '0; Rt_id = '0;
        UsesRt_id = 1'b0; Branch = 1'b0; Jump = 1'b0; MulDiv_id = 1'b0; HiLo_id = 1'b0;
        @(posedge clk); #1;
        //    tag            rst mr rtex rsid rtid urt br jp md hl  out  busy
        step("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0);
        step("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
        step("lu_rs",        0, 1, 5, 5, 0, 0, 0, 0, 0, 0, STL, 0);
        step("lu_release",   0, 0, 5, 5, 0, 0, 0, 0, 0, 0, NRM, 0);
        step("rt0_nostall",  0, 1, 0, 0, 0, 1, 0, 0, 0, 0, NRM, 0);
        step("lu_rt",        0, 1, 7, 3, 7, 1, 0, 0, 0, 0, STL, 0);
        step("rt_unused",    0, 1, 7, 3, 7, 0, 0, 0, 0, 0, NRM, 0);
        step("branch",       0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS, 0);
        step("jump",         0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLS, 0);
        step("branch_lu",    0, 1, 9, 9, 0, 0, 1, 0, 0, 0, STL, 0);
        step("branch_after", 0, 0, 9, 9, 0, 0, 1, 0, 0, 0, FLS, 0);
        step("idle2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
        // mult/div: start at T, busy T+1..T+4, mfhi released T+5
        step("md_start",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STA, 0);
        step("md_t1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1);
        step("hilo_t2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL, 1);
        step("hilo_br_t3",   0, 0, 0, 0, 0, 0, 1, 0, 0, 1, STL, 1);
        step("hilo_t4",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL, 1);
        step("hilo_rel_t5",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0);
        // LU and MD together, then a held MulDiv restarts the count
        step("md_start2",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STA, 0);
        step("md_lu_t1",     0, 1, 5, 5, 0, 0, 0, 0, 1, 0, STL, 1);
        step("md_held_t2",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 1);
        step("md_held_t3",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 1);
        step("md_held_t4",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 1);
        step("md_restart",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, STA, 0);
        step("busy_t1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1);
        step("reset_busy",   1, 0, 0, 0, 0, 0, 1, 0, 0, 1, STL, 1);
        step("hilo_post_rst",0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0);
        step("lu_pc",        0, 1, 4, 4, 0, 0, 0, 0, 0, 0, STL, 0);
        step("br_pc",        0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS, 0);
        step("idle_end",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
`ifdef HAZARD_PERF_EN
        checks++;
        assert (StallCnt === 32'(exp_stall)) else begin
            errors++;
            $error("FAIL stall_cnt observed=%0d expected=%0d", StallCnt, exp_stall);
        end
        checks++;
        assert (FlushCnt === 32'(exp_flush)) else begin
            errors++;
            $error("FAIL flush_cnt observed=%0d expected=%0d", FlushCnt, exp_flush);
        end
`endif
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the fetch stage's write enable and flush, and the IF/ID and ID/EX pipeline registers. It resolves load-use hazards, branch/jump redirects and stalls behind a multi-cycle multiply/divide unit. It sits beside the ID stage and is the only block allowed to stall or flush the front end.

## Interface
Parameters:
- MULDIV_CYCLES, 32: cycles the mult/div unit needs from start to HI/LO valid (legal 2..63).
- CNT_W, 6: width of the busy counter; must hold MULDIV_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- MemRead_ex  input  1  instruction in EX is a load.
- Rt_ex  input  5  load destination register in EX.
- Rs_id  input  5  rs of the instruction in ID.
- Rt_id  input  5  rt of the instruction in ID.
- UsesRt_id  input  1  ID instruction reads rt as a source.
- Branch  input  1  taken branch resolved in ID.
- Jump  input  1  jump decoded in ID.
- MulDiv_id  input  1  ID instruction is mult/multu/div/divu.
- HiLo_id  input  1  ID instruction is mfhi/mflo.
- IFWrite  output  1  PC update enable to fetch.
- IF_flush  output  1  redirect PC to jump target; IF/ID loads a NOP.
- IFIDWrite  output  1  IF/ID register write enable.
- Bubble_ex  output  1  ID/EX register loads a NOP.
- MdStart  output  1  one-cycle start pulse to the mult/div unit.
- MdBusy  output  1  mult/div in progress (registered).

## Operation
- States: RUN (no mult/div outstanding) and BUSY (counter running).
- Load-use hazard, combinational:
  - LU = MemRead_ex & (Rt_ex != 0) & ((Rt_ex == Rs_id) | (UsesRt_id & Rt_ex == Rt_id)).
- Mult/div hazard, combinational:
  - MD = (state == BUSY) & (HiLo_id | MulDiv_id).
- Stall = LU | MD.
  - While stalled: IFWrite = 0, IFIDWrite = 0, Bubble_ex = 1, IF_flush = 0, MdStart = 0.
- Redirect is taken only when not stalled.
  - IF_flush = (Branch | Jump) & ~Stall.
  - On redirect: IFWrite = 1 and IFIDWrite = 1; the IF/ID contents are replaced by a NOP.
- Normal flow (no stall): IFWrite = 1, IFIDWrite = 1, Bubble_ex = 0.
- Mult/div start:
  - MdStart = MulDiv_id & ~Stall & (state == RUN).
  - On MdStart: counter loads MULDIV_CYCLES and the next state is BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When the counter equals 1, the next state is RUN and the counter goes to 0.
  - A MulDiv_id or HiLo_id arriving in ID during BUSY stalls until the cycle after return to RUN, then proceeds (a MulDiv restarts the count).
- Priority: reset > Stall > redirect > normal.
- A branch held in ID during a stall keeps Branch asserted and redirects on the first unstalled cycle.

## Timing
- All outputs other than MdBusy are combinational from inputs and state; they apply in the same cycle.
- Load-use penalty: exactly 1 bubble. The load advances to MEM next edge, LU clears, and the dependent instruction proceeds.
- Mult/div: MdStart in cycle T. MdBusy is high for cycles T+1 .. T+MULDIV_CYCLES. mfhi in ID is released in cycle T+MULDIV_CYCLES+1.
- Reset, evaluated on a rising edge with reset high:
  - state = RUN, counter = 0, MdBusy = 0.
  - While reset is high: IFWrite = 0, IFIDWrite = 0, Bubble_ex = 1, IF_flush = 0, MdStart = 0.
- Reset mid-BUSY aborts the count; MdBusy is 0 after that edge.
- Rt_ex == 0 never stalls.
- LU and MD asserted together produce a single stall; no double bubble.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds output StallCnt[31:0], counting cycles with Stall = 1.
  - Adds output FlushCnt[31:0], counting cycles with IF_flush = 1.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- HAZARD_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- lw $5 in EX (MemRead_ex = 1, Rt_ex = 5), add using Rs_id = 5 -> one cycle of IFWrite = 0, IFIDWrite = 0, Bubble_ex = 1; next cycle all normal.
- Same, with Rt_ex = 0 and Rs_id = 0 -> no stall.
- Branch = 1 with no hazard -> IF_flush = 1, IFWrite = 1 in that cycle; Branch during LU -> IF_flush = 0, then IF_flush = 1 the following cycle.
- MulDiv_id at cycle 10 (MULDIV_CYCLES = 4) -> MdStart at 10; MdBusy 11..14; HiLo_id held from 12 stalls 12..14 and is released at 15.
- reset asserted at cycle 2 of BUSY -> MdBusy = 0 after the edge; a following HiLo_id is not stalled.
- With HAZARD_PERF_EN: a 1-cycle load-use stall followed by 1 branch -> StallCnt = 1, FlushCnt = 1.
